prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Sequential stage directly downstream of the 6x4 signed array multiplier.
- Consumes its 10-bit two's-complement product stream over a valid/ready handshake.
- Accumulates N_TERMS products into one frame sum and presents that sum on an output handshake.
- Together with the multiplier, forms a multiply-accumulate (dot-product) datapath.

Parameters:
- PW, 10, product input width (two's complement); matches the multiplier output.
- AW, 16, accumulator and result width (two's complement); must satisfy AW >= PW.
- N_TERMS, 4, products per frame; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous frame abort; ignored while rst_n=0.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block can accept prod.
- prod  input  PW  signed product from the multiplier.
- out_valid  output  1  acc_out holds a completed frame sum.
- out_ready  input  1  downstream accepts acc_out.
- acc_out  output  AW  signed frame sum.
- ovf  output  1  frame overflowed AW range; qualified by out_valid.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0.
  - acc_out=0; in_ready=1 in the first cycle after reset.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1.
  - On accept: acc <= acc + sign_extend(prod) (with the overflow rule below); ovf <= ovf | overflow.
  - If cnt==N_TERMS-1 on accept: cnt<=0 and go to HOLD. Otherwise cnt<=cnt+1.
- State HOLD:
  - in_ready=0, out_valid=1, acc_out=acc.
  - acc_out and ovf stay stable while out_ready=0.
  - When out_ready=1: return to ACCUM with acc<=0, ovf<=0.
- Latency and throughput:
  - The final sum is visible on out_valid the cycle after the last product is accepted.
  - Throughput is N_TERMS+1 cycles per frame with out_ready tied high. There is no overlap: input stalls during HOLD.
- acc_out is driven from the acc register (no combinational path from prod).
- acc_out=acc in all states, so it reads 0 after reset or clear.
- Arithmetic:
  - prod is sign-extended to AW+1 bits and added to acc.
  - Overflow means the AW+1-bit sum falls outside [-2^(AW-1), 2^(AW-1)-1].
  - The overflow result depends on PROD_ACCUM_SAT_EN.
- clear=1 (when rst_n=1):
  - Same effect as reset on the next edge. Overrides an accept or handover in the same cycle.
  - A partial frame is discarded; no out_valid is generated for it.
- N_TERMS=1: every accept goes straight to HOLD.
- Mid-frame reset or clear: the counter restarts at 0; the next frame uses exactly N_TERMS fresh products.

Optional Feature:
- Macro PROD_ACCUM_SAT_EN.
- Defined: on overflow, acc clamps to 2^(AW-1)-1 (positive overflow) or -2^(AW-1) (negative overflow). Subsequent adds continue from the clamped value.
- Undefined: acc wraps modulo 2^AW.
- ovf is set identically in both builds.

Decomposition:
- Shared package prod_accum_pkg holds:
  - state typedef {ACCUM, HOLD};
  - default width constants PW_DEF=10, AW_DEF=16;
  - the function returning AW-bit signed min/max.
- One natural sub-module: sat_add (AW-bit signed adder).
  - Outputs sum and overflow.
  - Performs the clamp under PROD_ACCUM_SAT_EN.

Test Plan:
- Basic frame: defaults, out_ready=1, products 5, -3, 100, -2 on consecutive cycles -> out_valid for one cycle with acc_out=100, ovf=0; in_ready=0 that cycle.
- Backpressure and bubbles: in_valid toggled 1,0,1,1,0,1 with products 7,8,9,10; out_ready held 0 for 3 cycles -> acc_out=34 stable across the hold, in_ready=0, and the next frame is accepted only after out_ready=1.
- Overflow, AW=11, four products of 511:
  - with PROD_ACCUM_SAT_EN -> acc_out=1023, ovf=1;
  - without -> acc_out=-4 (2044 mod 2048 as signed), ovf=1;
  - next frame of 1,1,1,1 -> acc_out=4, ovf=0.
- Negative extreme: AW=11, four products of -512 -> saturated build -1024 with ovf=1 (the sum reaches -1024 after two products and stays clamped); wrap build -2048 wraps to 0 with ovf=1.
- Clear mid-frame: accept 20, 30, assert clear with in_valid=1 prod=40, then accept 1, 2, 3, 4 -> single out_valid with acc_out=10.
- Reset mid-HOLD: rst_n=0 one cycle while out_valid=1 -> next cycle out_valid=0, in_ready=1, acc_out=0, ovf=0.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared types, default widths and range helper for prod_accum
// Contents:
//   PW_DEF, AW_DEF : default product and accumulator widths
//   state_t        : ACCUM (collecting products) / HOLD (presenting frame sum)
//   aw_limit()     : most positive or most negative value of an aw-bit signed number
package prod_accum_pkg;

    localparam int PW_DEF = 10;
    localparam int AW_DEF = 16;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic signed [31:0] aw_limit(input int aw, input logic want_max);
        logic signed [31:0] half;
        half = 32'sd1 <<< (aw - 1);
        return want_max ? (half - 32'sd1) : -half;
    endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// rtl/prod_accum_sat_add.sv - AW-bit signed accumulate step with overflow detect
// Build option: PROD_ACCUM_SAT_EN clamps the result on overflow; otherwise it wraps.
// Ports:
//   a   in  AW  current accumulator value (signed)
//   b   in  PW  product to add (signed, sign-extended internally)
//   sum out AW  next accumulator value
//   ovf out 1   AW+1-bit true sum lies outside the AW-bit signed range
module prod_accum_sat_add
    import prod_accum_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [PW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);

    logic signed [AW:0] wide;

    // One guard bit is enough: |b| never exceeds the AW-bit range when AW >= PW.
    assign wide = {a[AW-1], a} + {{(AW + 1 - PW){b[PW-1]}}, b};

    // Guard bit disagreeing with the AW-bit sign means the result left the range.
    assign ovf = wide[AW] ^ wide[AW-1];

`ifdef PROD_ACCUM_SAT_EN
    localparam logic signed [31:0] MAX_V = aw_limit(AW, 1'b1);
    localparam logic signed [31:0] MIN_V = aw_limit(AW, 1'b0);

    // The guard bit carries the true sign, so it selects which rail to clamp to.
    always_comb begin
        sum = wide[AW-1:0];
        if (ovf) begin
            sum = wide[AW] ? MIN_V[AW-1:0] : MAX_V[AW-1:0];
        end
    end
`else
    assign sum = wide[AW-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - accumulates N_TERMS signed products into one frame sum
// Build option: PROD_ACCUM_SAT_EN (saturating accumulate; default wraps modulo 2^AW).
// Ports:
//   clk       in  1   system clock
//   rst_n     in  1   synchronous active-low reset
//   clear     in  1   synchronous frame abort
//   in_valid  in  1   prod valid
//   in_ready  out 1   accepting products (ACCUM state)
//   prod      in  PW  signed product
//   out_valid out 1   acc_out holds a completed frame sum (HOLD state)
//   out_ready in  1   downstream takes acc_out
//   acc_out   out AW  accumulator register
//   ovf       out 1   frame overflowed, qualified by out_valid
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PW      = PW_DEF,
    parameter int AW      = AW_DEF,
    parameter int N_TERMS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [PW-1:0] prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] acc_out,
    output logic                 ovf
);

    // A one-term frame still gets a 1-bit counter that simply stays at zero.
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  acc;
    logic                  ovf_r;
    logic signed [AW-1:0]  next_acc;
    logic                  add_ovf;

    prod_accum_sat_add #(
        .PW(PW),
        .AW(AW)
    ) u_sat_add (
        .a   (acc),
        .b   (prod),
        .sum (next_acc),
        .ovf (add_ovf)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign acc_out   = acc;
    assign ovf       = ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf_r <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= next_acc;
                        ovf_r <= ovf_r | add_ovf;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf_r <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - self-checking bench for prod_accum (AW=16 and AW=11 instances)
module tb_prod_accum;

    localparam int N = 4;
`ifdef PROD_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  prod = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] acc_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [10:0] acc_b;

    int errors = 0;
    int checks = 0;

    // Reference model: products of the frame in progress (or the completed frame while pending).
    int frame_q[$];
    bit pend = 1'b0;

    logic        exp_in_ready, exp_out_valid, exp_ovf_a, exp_ovf_b;
    logic [15:0] exp_acc_a;
    logic [10:0] exp_acc_b;

    always #5 clk = ~clk;

    prod_accum u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .prod      (prod),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .acc_out   (acc_a),
        .ovf       (ovf_a)
    );

    prod_accum #(
        .PW(10),
        .AW(11),
        .N_TERMS(N)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .prod      (prod),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .acc_out   (acc_b),
        .ovf       (ovf_b)
    );

    // Running sum of a product list in an aw-bit signed accumulator, plus sticky overflow.
    function automatic void fold(input int q[$], input int aw, output int s, output bit ov);
        int hi;
        int lo;
        hi = (1 << (aw - 1)) - 1;
        lo = -(1 << (aw - 1));
        s  = 0;
        ov = 1'b0;
        foreach (q[i]) begin
            s = s + q[i];
            if (s > hi || s < lo) begin
                ov = 1'b1;
                if (SAT) s = (s > hi) ? hi : lo;
                else     s = (s > hi) ? s - (1 << aw) : s + (1 << aw);
            end
        end
    endfunction

    task automatic model_expect();
        int  s;
        bit  ov;
        exp_in_ready  = !pend;
        exp_out_valid = pend;
        fold(frame_q, 16, s, ov);
        exp_acc_a = 16'(s);
        exp_ovf_a = ov;
        fold(frame_q, 11, s, ov);
        exp_acc_b = 11'(s);
        exp_ovf_b = ov;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, sample at +1.
    task automatic step(input logic v, input int p, input logic ordy, input logic clr, input logic rn);
        in_valid  = v;
        prod      = 10'(p);
        out_ready = ordy;
        clear     = clr;
        rst_n     = rn;
        @(posedge clk);
        if (!rn || clr) begin
            frame_q.delete();
            pend = 1'b0;
        end else if (!pend) begin
            if (v) begin
                frame_q.push_back(p);
                if (frame_q.size() == N) pend = 1'b1;
            end
        end else if (ordy) begin
            frame_q.delete();
            pend = 1'b0;
        end
        model_expect();
        #1;
        rst_n    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b/%b exp=1", in_ready_a, in_ready_b); end
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b/%b exp=0", out_valid_a, out_valid_b); end
        checks++; if (acc_a !== 16'd0 || acc_b !== 11'd0) begin errors++; $display("FAIL reset_acc got=%0d/%0d exp=0", $signed(acc_a), $signed(acc_b)); end
        checks++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b/%b exp=0", ovf_a, ovf_b); end
    endtask

    task automatic test_basic_frame();
        int prods[4] = '{5, -3, 100, -2};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, prods[i], 1'b1, 1'b0, 1'b1);
            if (i < 3) begin
                checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_early_valid term=%0d got=%b exp=0", i, out_valid_a); end
            end
        end
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid_a); end
        checks++; if ($signed(acc_a) !== 16'sd100) begin errors++; $display("FAIL basic_acc got=%0d exp=100", $signed(acc_a)); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", ovf_a); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL basic_in_ready got=%b exp=0", in_ready_a); end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid_a !== 1'b0 || acc_a !== 16'd0) begin errors++; $display("FAIL basic_single_valid got v=%b acc=%0d exp v=0 acc=0", out_valid_a, $signed(acc_a)); end
    endtask

    task automatic test_backpressure();
        logic vpat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   ppat[6] = '{7, 99, 8, 9, 99, 10};
        for (int i = 0; i < 6; i++) step(vpat[i], ppat[i], 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid_a !== 1'b1 || $signed(acc_a) !== 16'sd34) begin errors++; $display("FAIL bp_frame got v=%b acc=%0d exp v=1 acc=34", out_valid_a, $signed(acc_a)); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 55, 1'b0, 1'b0, 1'b1);
            checks++; if ($signed(acc_a) !== 16'sd34 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got acc=%0d v=%b rdy=%b exp acc=34 v=1 rdy=0", i, $signed(acc_a), out_valid_a, in_ready_a);
            end
        end
        step(1'b1, 55, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || acc_a !== 16'd0) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b acc=%0d exp v=0 rdy=1 acc=0", out_valid_a, in_ready_a, $signed(acc_a));
        end
    endtask

    task automatic test_overflow();
        logic [10:0] exp_b;
        exp_b = SAT ? 11'sd1023 : -11'sd4;
        for (int i = 0; i < 4; i++) step(1'b1, 511, 1'b1, 1'b0, 1'b1);
        checks++; if (acc_b !== exp_b || ovf_b !== 1'b1 || out_valid_b !== 1'b1) begin
            errors++; $display("FAIL ovf_pos got acc=%0d ovf=%b v=%b exp acc=%0d ovf=1 v=1", $signed(acc_b), ovf_b, out_valid_b, $signed(exp_b));
        end
        checks++; if ($signed(acc_a) !== 16'sd2044 || ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_pos_wide got acc=%0d ovf=%b exp 2044/0", $signed(acc_a), ovf_a); end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1, 1'b0, 1'b1);
        checks++; if ($signed(acc_b) !== 11'sd4 || ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_next_frame got acc=%0d ovf=%b exp 4/0", $signed(acc_b), ovf_b); end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_negative();
        logic [10:0] exp_b;
        exp_b = SAT ? -11'sd1024 : 11'sd0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, -512, 1'b1, 1'b0, 1'b1);
            if (i == 1) begin
                checks++; if ($signed(acc_b) !== -11'sd1024 || ovf_b !== 1'b0) begin errors++; $display("FAIL neg_two got acc=%0d ovf=%b exp -1024/0", $signed(acc_b), ovf_b); end
            end
        end
        checks++; if (acc_b !== exp_b || ovf_b !== 1'b1) begin errors++; $display("FAIL neg_final got acc=%0d ovf=%b exp acc=%0d ovf=1", $signed(acc_b), ovf_b, $signed(exp_b)); end
        checks++; if ($signed(acc_a) !== -16'sd2048 || ovf_a !== 1'b0) begin errors++; $display("FAIL neg_wide got acc=%0d ovf=%b exp -2048/0", $signed(acc_a), ovf_a); end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        int   got_valid;
        step(1'b1, 20, 1'b1, 1'b0, 1'b1);
        step(1'b1, 30, 1'b1, 1'b0, 1'b1);
        step(1'b1, 40, 1'b1, 1'b1, 1'b1);
        checks++; if (acc_a !== 16'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL clear_state got acc=%0d v=%b rdy=%b exp 0/0/1", $signed(acc_a), out_valid_a, in_ready_a);
        end
        got_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b1, 1'b0, 1'b1);
            if (out_valid_a === 1'b1) got_valid++;
        end
        checks++; if (got_valid != 1 || $signed(acc_a) !== 16'sd10) begin errors++; $display("FAIL clear_next got valids=%0d acc=%0d exp 1/10", got_valid, $signed(acc_a)); end
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 4; i++) step(1'b1, 511, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid_b !== 1'b1 || ovf_b !== 1'b1) begin errors++; $display("FAIL rhold_pre got v=%b ovf=%b exp 1/1", out_valid_b, ovf_b); end
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            errors++; $display("FAIL rhold_hs got v=%b/%b rdy=%b/%b exp v=0 rdy=1", out_valid_a, out_valid_b, in_ready_a, in_ready_b);
        end
        checks++; if (acc_a !== 16'd0 || acc_b !== 11'd0 || ovf_b !== 1'b0 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL rhold_data got acc=%0d/%0d ovf=%b/%b exp 0", $signed(acc_a), $signed(acc_b), ovf_a, ovf_b);
        end
    endtask

    task automatic test_random();
        logic v, ordy, clr;
        int   p;
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 39) == 0);
            p    = int'($urandom_range(0, 1023)) - 512;
            step(v, p, ordy, clr, 1'b1);
            checks++; if (in_ready_a !== exp_in_ready || in_ready_b !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b/%b exp=%b", c, in_ready_a, in_ready_b, exp_in_ready); end
            checks++; if (out_valid_a !== exp_out_valid || out_valid_b !== exp_out_valid) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b/%b exp=%b", c, out_valid_a, out_valid_b, exp_out_valid); end
            checks++; if (acc_a !== exp_acc_a || ovf_a !== exp_ovf_a) begin errors++; $display("FAIL rand_a cyc=%0d got acc=%0d ovf=%b exp acc=%0d ovf=%b", c, $signed(acc_a), ovf_a, $signed(exp_acc_a), exp_ovf_a); end
            checks++; if (acc_b !== exp_acc_b || ovf_b !== exp_ovf_b) begin errors++; $display("FAIL rand_b cyc=%0d got acc=%0d ovf=%b exp acc=%0d ovf=%b", c, $signed(acc_b), ovf_b, $signed(exp_acc_b), exp_ovf_b); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_negative();
        test_clear();
        test_reset_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
